// File: rtl/logic_reduce_stream_pkg.sv
// rtl/logic_reduce_stream_pkg.sv - op and FSM state encodings shared by the logic reducer
package logic_reduce_stream_pkg;

  typedef enum logic [1:0] {
    OP_OR  = 2'b00,
    OP_AND = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

endpackage

// File: rtl/logic_reduce_op.sv
// rtl/logic_reduce_op.sv - combinational two-operand bitwise fold step
module logic_reduce_op
  import logic_reduce_stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] y
);

  // NOR folds as OR; the final inversion is applied once when the frame closes.
  always_comb begin
    y = a | b;
    case (op)
      OP_AND:  y = a & b;
      OP_XOR:  y = a ^ b;
      default: y = a | b;
    endcase
  end

endmodule

// File: rtl/logic_reduce_stream.sv
// rtl/logic_reduce_stream.sv - folds a frame of beats into one result with valid/ready on both sides
module logic_reduce_stream
  import logic_reduce_stream_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16,
  localparam int CW       = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  input  logic [1:0]       s_op,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CW-1:0]    m_beats,
  output logic             m_err
);

  state_e           state;
  op_e              op_q;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             first;
  op_e              op_sel;
  logic [WIDTH-1:0] fold;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    cnt_next;
  logic             close;

  assign s_ready  = !m_valid || m_ready;
  assign accept   = s_valid && s_ready;
  assign first    = (state == ST_IDLE);
  assign op_sel   = first ? op_e'(s_op) : op_q;
  assign acc_next = first ? s_data : fold;
  assign cnt_next = first ? CW'(1) : cnt + CW'(1);
  // Reaching MAX_BEATS closes the frame even without s_last, so cnt cannot wrap.
  assign close    = accept && (s_last || (cnt_next == CW'(MAX_BEATS)));

  logic_reduce_op #(.WIDTH(WIDTH)) u_op (
    .a  (acc),
    .b  (s_data),
    .op (op_q),
    .y  (fold)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      op_q    <= OP_OR;
      acc     <= '0;
      cnt     <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_beats <= '0;
      m_err   <= 1'b0;
    end else begin
      if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
      if (accept) begin
        acc  <= acc_next;
        cnt  <= cnt_next;
        op_q <= op_sel;
        if (close) begin
          m_data  <= (op_sel == OP_NOR) ? ~acc_next : acc_next;
          m_beats <= cnt_next;
          m_err   <= !s_last;
          m_valid <= 1'b1;
          state   <= ST_IDLE;
        end else begin
          state <= ST_ACCUM;
        end
      end
    end
  end

endmodule
